// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default sizes for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  // Default memory geometry, shared with the datapath.
  localparam int unsigned DefaultAw = 10;
  localparam int unsigned DefaultDw = 32;

  // Bit positions inside the one-hot grant vector.
  localparam int unsigned GntLd = 0;
  localparam int unsigned GntD  = 1;
  localparam int unsigned GntF  = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_D    = 2'd2,
    OWN_F    = 2'd3
  } owner_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational winner selection: loader first, then data, then fetch, except
// that a starved fetch overtakes data. The loader is never overtaken.
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
(
  input  logic       ld_req_i,
  input  logic       d_req_i,
  input  logic       f_req_i,
  input  logic       starve_hit_i,
  output logic [2:0] gnt_oh_o
);

  // Fixed priority with the starvation override between data and fetch.
  always_comb begin
    gnt_oh_o = '0;
    if (ld_req_i) begin
      gnt_oh_o[GntLd] = 1'b1;
    end else if (d_req_i && !(starve_hit_i && f_req_i)) begin
      gnt_oh_o[GntD] = 1'b1;
    end else if (f_req_i) begin
      gnt_oh_o[GntF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the multicycle core: loader writes, datapath
// loads/stores and instruction fetches share one port. Writes complete in the
// issue cycle; reads hold the port until their data returns MEM_LAT cycles later.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = DefaultAw,
  parameter int unsigned DW         = DefaultDw,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ld_req_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_wdata_i,
  output logic          ld_gnt_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  input  logic          f_req_i,
  input  logic [AW-1:0] f_addr_i,
  output logic          f_gnt_o,
  output logic          f_rvalid_o,
  output logic [DW-1:0] f_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int unsigned ScW = $clog2(STARVE_MAX + 1);
  localparam int unsigned LcW = 3;

  state_e         state_q, state_d;
  logic [LcW-1:0] lat_cnt_q, lat_cnt_d;
  logic [ScW-1:0] starve_cnt_q, starve_cnt_d;
  owner_e         owner_q, owner_d;
  logic [DW-1:0]  d_rdata_q, d_rdata_d;
  logic [DW-1:0]  f_rdata_q, f_rdata_d;

  logic [2:0] gnt_oh;
  logic [2:0] gnt_idle;
  logic       starve_hit;
  logic       issue_rd;
  logic       rd_done;

  assign starve_hit = (starve_cnt_q == ScW'(STARVE_MAX));
  assign gnt_idle   = (state_q == ST_IDLE) ? gnt_oh : 3'b000;
  assign issue_rd   = gnt_idle[GntF] || (gnt_idle[GntD] && !d_we_i);
  assign rd_done    = (state_q == ST_RD_WAIT) && (lat_cnt_q == LcW'(MEM_LAT));

  arb_prio_sel u_prio_sel (
    .ld_req_i     (ld_req_i),
    .d_req_i      (d_req_i),
    .f_req_i      (f_req_i),
    .starve_hit_i (starve_hit),
    .gnt_oh_o     (gnt_oh)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only reads occupy the port beyond the issue cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (issue_rd) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_done)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Latency counter, read owner, starvation counter and held read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
      d_rdata_q    <= '0;
      f_rdata_q    <= '0;
    end else begin
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      d_rdata_q    <= d_rdata_d;
      f_rdata_q    <= f_rdata_d;
    end
  end

  // Next values for counters and owner.
  always_comb begin
    lat_cnt_d    = lat_cnt_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    if (state_q == ST_IDLE) begin
      if (issue_rd) begin
        lat_cnt_d = LcW'(1);
        owner_d   = gnt_idle[GntF] ? OWN_F : OWN_D;
      end
    end else if (rd_done) begin
      lat_cnt_d = '0;
      owner_d   = OWN_NONE;
    end else begin
      lat_cnt_d = lat_cnt_q + LcW'(1);
    end
    if (gnt_idle[GntF]) begin
      starve_cnt_d = '0;
    end else if (gnt_idle[GntD] && f_req_i && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + ScW'(1);
    end
    d_rdata_d = d_rdata_o;
    f_rdata_d = f_rdata_o;
  end

  // Outputs: grants and memory strobe only in IDLE; read data passes through on rvalid.
  always_comb begin
    ld_gnt_o    = gnt_idle[GntLd];
    d_gnt_o     = gnt_idle[GntD];
    f_gnt_o     = gnt_idle[GntF];
    mem_en_o    = |gnt_idle;
    mem_we_o    = gnt_idle[GntLd] || (gnt_idle[GntD] && d_we_i);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_idle[GntLd]) begin
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
    end else if (gnt_idle[GntD]) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (gnt_idle[GntF]) begin
      mem_addr_o  = f_addr_i;
    end
    d_rvalid_o = rd_done && (owner_q == OWN_D);
    f_rvalid_o = rd_done && (owner_q == OWN_F);
    d_rdata_o  = d_rvalid_o ? mem_rdata_i : d_rdata_q;
    f_rdata_o  = f_rvalid_o ? mem_rdata_i : f_rdata_q;
    busy_o     = (state_q == ST_RD_WAIT);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multicycle RISC-V core between three requesters: the boot loader (programs memory from the 32-bit initialize word stream), the datapath load/store path, and the instruction fetch path.
- Sits between the datapath/controller pair and the memory macro.
- Issues at most one access at a time, and times read data return against a fixed memory latency.
- Prevents fetch starvation by data traffic.

Parameters:
- AW, 10, word-address width of the memory.
- DW, 32, data width.
- MEM_LAT, 1, cycles from the issue cycle to valid mem_rdata; legal range 1..4.
- STARVE_MAX, 4, consecutive data grants that may bypass a pending fetch before fetch wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ld_req  in  1  loader write request; hold until ld_gnt.
- ld_addr  in  AW  loader word address.
- ld_wdata  in  DW  loader write data (initialize word).
- ld_gnt  out  1  loader write accepted this cycle.
- d_req  in  1  datapath access request; hold until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  datapath word address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  datapath access accepted this cycle.
- d_rvalid  out  1  load data valid, one-cycle pulse.
- d_rdata  out  DW  load data.
- f_req  in  1  fetch request; hold until f_gnt.
- f_addr  in  AW  fetch word address.
- f_gnt  out  1  fetch accepted this cycle.
- f_rvalid  out  1  instruction valid, one-cycle pulse.
- f_rdata  out  DW  instruction word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after issue.
- busy  out  1  access in flight (state is not IDLE).

Behaviour:
- FSM states:
  - IDLE: no access in flight.
  - RD_WAIT: a read is outstanding; lat_cnt counts 1..MEM_LAT.
- Reset (reset=0, asynchronous):
  - State IDLE, lat_cnt=0, starve_cnt=0, owner=NONE.
  - All gnt, rvalid, mem_en, mem_we and busy outputs are 0; rdata outputs are 0.
- IDLE arbitration is combinational, in the same cycle as the request.
  - Priority order: ld > d > f.
  - Exception: if starve_cnt==STARVE_MAX and f_req=1, f beats d. Ld always wins.
- Issue cycle:
  - The winner's gnt=1 and mem_en=1.
  - mem_addr and mem_wdata come from the winner.
  - mem_we = 1 for a loader grant, d_we for a data grant, 0 for a fetch grant.
  - Requesters sample gnt on the clock edge and may change their request afterwards.
- Write grant (ld, or d with d_we=1): completes in the issue cycle; the FSM stays IDLE. Back-to-back writes are possible every cycle.
- Read grant (d with d_we=0, or f):
  - Go to RD_WAIT and latch owner.
  - rvalid pulses for the owner exactly MEM_LAT cycles after the issue cycle; rdata = mem_rdata in that cycle, passed through.
  - Return to IDLE on the cycle after the rvalid cycle. The next issue is no earlier than that cycle, so read occupancy is MEM_LAT+1 cycles.
- While in RD_WAIT, all gnt outputs are 0 and mem_en=0. New requests wait.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each d grant while f_req=1.
  - Clears on an f grant.
  - Holds otherwise, including across ld grants.
- rdata outputs hold their last value outside rvalid. Consumers must qualify with rvalid.
- A request deasserted before its grant is legal; that requester is simply not served.
- Reset asserted mid-read: the read is abandoned, no rvalid is produced, and all state clears immediately.
- Address width is AW with no byte lanes. Byte and halfword selection is handled upstream in the datapath.

Decomposition:
- Shared package holds:
  - Owner encoding: OWN_NONE=2'd0, OWN_LD=2'd1, OWN_D=2'd2, OWN_F=2'd3.
  - State encoding: ST_IDLE, ST_RD_WAIT.
  - Default AW and DW constants, shared with the datapath.
- One natural sub-module, arb_prio_sel: the purely combinational winner selection from ld_req, d_req, f_req and starve_hit. It outputs a one-hot grant vector and is unit-testable on its own.
- The FSM, counters and mux stay in mem_port_arbiter.

Test Plan:
1. Loader burst: ld_req held for 4 cycles with addr 0..3 and data 32'h00500093, ... -> ld_gnt=1 each cycle, mem_we=1, mem_addr 0..3 in order, busy stays 0.
2. Fetch read, MEM_LAT=2: f_req with f_addr=5 -> f_gnt in cycle T, f_rvalid only in cycle T+2 with f_rdata=mem_rdata, next grant no earlier than T+3.
3. Contention: ld_req, d_req and f_req all set -> grant order ld, then d, then f, each issued only after any prior read completes.
4. Starvation, STARVE_MAX=4: d_req (loads) and f_req held continuously -> 4 d grants, then f_gnt. starve_cnt returns to 0, and the following grant goes to d.
5. Store vs load: d_we=1 then d_we=0 on the same address -> the store completes with no d_rvalid; the load returns the stored value after MEM_LAT cycles.
6. Reset in RD_WAIT: reset=0 one cycle after f_gnt -> no f_rvalid, busy=0 and all gnt=0 immediately. After release, a new f_req is granted in the first IDLE cycle.
